// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types for the store buffer: store type codes, entry layout, store predicate
package sb_pkg;

    localparam int SB_AW = 32;

    typedef enum logic [2:0] {
        ST_W = 3'b000,
        ST_H = 3'b001,
        ST_B = 3'b010
    } st_type_e;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [31:0]      data;
        st_type_e         typ;
    } sb_entry_t;

    function automatic logic is_store(st_type_e t);
        return (t == ST_W) || (t == ST_H) || (t == ST_B);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline/data_mem facing bundle of the store buffer; SB_LOAD_FWD_EN adds forwarding signals
interface store_buffer_if
    import sb_pkg::*;
#(
    parameter int AW    = SB_AW,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_type;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          drain_en;
    logic          mem_we;
    logic [AW-1:0] mem_adress;
    logic [31:0]   wr_data;
    logic [2:0]    data_type;
    logic          sb_empty;
    logic [CW-1:0] sb_count;
`ifdef SB_LOAD_FWD_EN
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;
`endif

    modport slave (
        input  st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, drain_en,
        output st_ready, ld_hazard, mem_we, mem_adress, wr_data, data_type, sb_empty, sb_count
`ifdef SB_LOAD_FWD_EN
        , output ld_fwd_valid, ld_fwd_data
`endif
    );

    modport master (
        output st_valid, st_addr, st_data, st_type, ld_valid, ld_addr, drain_en,
        input  st_ready, ld_hazard, mem_we, mem_adress, wr_data, data_type, sb_empty, sb_count
`ifdef SB_LOAD_FWD_EN
        , input ld_fwd_valid, ld_fwd_data
`endif
    );

endinterface

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - sb_match: per-entry word compare and youngest-match select, ordered relative to tail
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-3:0]    slot_waddr [DEPTH],
    input  logic [DEPTH-1:0] slot_is_word,
    input  logic [AW-3:0]    ld_waddr,
    input  logic [IW-1:0]    tail,
    output logic             any_match,
    output logic [IW-1:0]    youngest_idx,
    output logic             youngest_is_word
);

    // Walk oldest to youngest (tail-DEPTH .. tail-1) so the last hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        any_match        = 1'b0;
        youngest_idx     = '0;
        youngest_is_word = 1'b0;
        idx              = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - IW'(k);
            if (valid[idx] && (slot_waddr[idx] == ld_waddr)) begin
                any_match        = 1'b1;
                youngest_idx     = idx;
                youngest_is_word = slot_is_word[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO to data_mem with load hazard check; SB_LOAD_FWD_EN enables sw forwarding
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    sb_entry_t        slot_q [DEPTH];
    sb_entry_t        slot_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    logic [AW-3:0]    slot_waddr [DEPTH];
    logic [DEPTH-1:0] slot_is_word;
    logic             any_match, youngest_is_word;
    logic [IW-1:0]    youngest_idx;
    logic             unused_ld_lane;

    // A full buffer refuses stores even while it drains that same cycle.
    assign bus.st_ready  = (count_q != CW'(DEPTH));
    assign bus.sb_empty  = (count_q == '0);
    assign bus.sb_count  = count_q;
    assign pop           = bus.drain_en && (count_q != '0);
    assign push          = bus.st_valid && bus.st_ready && is_store(st_type_e'(bus.st_type));

    assign bus.mem_we     = pop;
    assign bus.mem_adress = slot_q[head_q].addr[AW-1:0];
    assign bus.wr_data    = slot_q[head_q].data;
    assign bus.data_type  = slot_q[head_q].typ;

    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IW'(1);
        end
        if (push) begin
            slot_d[tail_q]  = '{addr: bus.st_addr, data: bus.st_data, typ: st_type_e'(bus.st_type)};
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + IW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_waddr[i]   = slot_q[i].addr[AW-1:2];
            slot_is_word[i] = (slot_q[i].typ == ST_W);
        end
    end

    sb_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .valid            (valid_q),
        .slot_waddr       (slot_waddr),
        .slot_is_word     (slot_is_word),
        .ld_waddr         (bus.ld_addr[AW-1:2]),
        .tail             (tail_q),
        .any_match        (any_match),
        .youngest_idx     (youngest_idx),
        .youngest_is_word (youngest_is_word)
    );

    assign unused_ld_lane = ^bus.ld_addr[1:0];

`ifdef SB_LOAD_FWD_EN
    assign bus.ld_hazard    = bus.ld_valid && any_match && !youngest_is_word;
    assign bus.ld_fwd_valid = bus.ld_valid && any_match && youngest_is_word;
    assign bus.ld_fwd_data  = slot_q[youngest_idx].data;
`else
    logic unused_youngest;
    assign bus.ld_hazard   = bus.ld_valid && any_match;
    assign unused_youngest = ^{youngest_idx, youngest_is_word};
`endif

endmodule
